instgen_tiled: RTL and testbench
================================

Name: instgen_tiled

Overview:
- Parametrised successor to the single-pass CONV instruction generator.
- Accepts one CSR conv command and emits one stride instruction per output pixel per output-channel tile to the decoder, over a valid/ready handshake.
- Adds separate H/W strides, output-channel tiling, incremental address generation (no per-step multiplier) and an end-of-command pulse.
- Sits between the CSR block and the decoder.

Parameters:
- ADDR_W, 32, CSR/SoC byte-address width
- DATA_W, 32, CSR dimension field width
- FRAM_AW, 14, feature BRAM word-address width
- KRAM_AW, 12, kernel BRAM word-address width
- CHOUT_TILE, 8, output channels processed per tile by the PE array

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- feature_baseaddr, kernel_baseaddr, output_baseaddr  in  ADDR_W  byte addresses
- feature_width, feature_height, feature_chin, feature_chout  in  DATA_W  input geometry
- output_width, output_height  in  DATA_W  output geometry
- kernel_sizeh, kernel_sizew  in  8  kernel dims
- stride_h, stride_w  in  8  strides (0 treated as 1)
- has_bias, has_relu  in  1  flags
- csrcmd_valid  in  1 / instgen_ready  out  1  command handshake
- inst_feature_baseaddr  out  FRAM_AW
- inst_kernel_baseaddr  out  KRAM_AW
- inst_wb_baseaddr  out  FRAM_AW
- inst_wb_ch_offset  out  DATA_W
- inst_chout_cnt  out  DATA_W  channels in this tile
- inst_feature_chin, inst_feature_width, inst_feature_height  out  DATA_W  copied fields
- inst_kernel_sizeh, inst_kernel_sizew  out  8  copied fields
- inst_has_bias, inst_has_relu  out  1  copied fields
- inst_valid  out  1 / decoder_ready  in  1  instruction handshake
- tlast  out  1  marks final instruction of the command
- cmd_done  out  1  one-cycle pulse when the command completes

Behaviour:
- Reset: state IDLE; all inst_* outputs, inst_valid, tlast and cmd_done are 0; instgen_ready is 1.
- Command capture: on csrcmd_valid && instgen_ready, all fields are registered. Byte addresses are converted to word addresses via addr[2 +: AW].
- INIT (2 cycles) precomputes:
  - row_step = stride_h*feature_width
  - plane = output_width*output_height
  - ktile_step = CHOUT_TILE*chin*kh*kw (kernel words)
  - wtile_step = CHOUT_TILE*plane
- Zero dimension: if any of output_width, output_height or chout is 0, go INIT→DONE with no instructions.
- Loop order: tile t (outer), oy, ox (inner). ox < output_width, oy < output_height, t < ceil(chout/CHOUT_TILE).
- Incremental addressing:
  - feature addr = fbase + row_acc + col_acc; col_acc += stride_w per ox; row_acc += row_step per oy.
  - kernel addr = kbase + t*ktile_step (accumulated).
  - wb addr = obase + t*wtile_step + oy*output_width + ox (accumulated +1 per instruction).
  - inst_chout_cnt = min(CHOUT_TILE, chout − t*CHOUT_TILE).
  - inst_wb_ch_offset = plane.
- Width rules: all address sums truncate modulo 2^AW (wrap, no saturation). Products are computed in DATA_W and truncated.
- EXEC:
  - inst_* are registered and inst_valid=1.
  - Outputs are held stable while inst_valid && !decoder_ready.
  - On handshake, the next instruction is presented the next cycle (1 instruction/cycle sustained).
  - tlast=1 is registered, coincident with the last instruction (ox, oy, t all at max).
- DONE: entered after the tlast handshake. cmd_done pulses for 1 cycle, then IDLE the next cycle. First instruction appears 3 cycles after command accept.
- instgen_ready=1 only in IDLE. Commands are ignored otherwise.
- Reset mid-command: all state is cleared immediately. No pending instruction survives.

Optional Feature:
- INSTGEN_STALL_CNT_EN defined: adds output stall_cnt [31:0].
  - Counts cycles with inst_valid && !decoder_ready.
  - Clears on command accept; saturates at all-ones.
- Not defined: port and counter are absent.

Decomposition:
- Package instgen_pkg holds:
  - state enum (IDLE, INIT, EXEC, DONE)
  - instruction struct typedef
  - the 2-bit byte→word shift constant
- One natural sub-module: instgen_addr_acc, a loadable/clearable/steppable AW-bit accumulator used for the col, row, kernel-tile and wb accumulators.

Test Plan:
- Basic run: W=H=6, k=3x3, stride 1/1, OW=OH=4, chout=8, CHOUT_TILE=8 → 16 instructions. Feature addrs fbase+{0,1,2,3,6,…,21}; wb obase+0..15; tlast on the 16th; cmd_done one cycle after.
- Asymmetric stride: W=8, H=7, k=3, stride_h=2, stride_w=3, OW=2, OH=3 → feature offsets {0,3,16,19,32,35}.
- Tiling: chout=20, CHOUT_TILE=8, plane=4 → 12 instructions:
  - chout_cnt 8,8,4
  - kernel addr steps by 8*chin*9
  - wb tile bases obase+0, 32, 64
- Backpressure: decoder_ready random at 30% → outputs stable while stalled; no instruction lost or duplicated; stall_cnt (if enabled) equals stall cycles.
- Zero dims: output_width=0 → no inst_valid; cmd_done pulses; ready returns.
- Reset mid-EXEC at instruction 5 → outputs 0, IDLE next cycle; a new command runs cleanly.

Source files
------------

// File: rtl/instgen_pkg.sv
// Shared types and constants for the tiled CONV instruction generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instgen_pkg;

  // Command sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    EXEC = 2'd2,
    DONE = 2'd3
  } state_t;

  // Byte address to 32-bit word address: drop the two low bits.
  localparam int BYTE2WORD_SH = 2;

  // Fixed-width part of an emitted instruction (copied straight from the command).
  typedef struct packed {
    logic [7:0] kernel_sizeh;
    logic [7:0] kernel_sizew;
    logic       has_bias;
    logic       has_relu;
  } inst_fixed_t;

endpackage

// File: rtl/instgen_addr_acc.sv
// Loadable / clearable / steppable address accumulator (wraps modulo 2^AW).
// Latency: 1 cycle, the new value is visible the cycle after clr/load/step.
// Backpressure: none; the caller gates step. Priority is clr > load > step.
//
// Ports: clk, rst (async, active high), clr, load + load_val, step + step_val, acc.
module instgen_addr_acc
  import instgen_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          step,
  input  logic [AW-1:0] step_val,
  output logic [AW-1:0] acc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (step) begin
      acc <= acc + step_val;
    end
  end

endmodule

// File: rtl/instgen_tiled.sv
// Turns one CSR conv command into one stride instruction per output pixel per output-channel tile.
// Latency: first instruction 3 cycles after command accept, then 1 instruction/cycle; cmd_done 1 cycle after the tlast handshake.
// Backpressure: inst_* held stable while inst_valid && !decoder_ready; commands accepted only in IDLE (instgen_ready).
//
// Ports: clk, rst (async, active high); command fields + csrcmd_valid/instgen_ready;
//        inst_* instruction fields + inst_valid/decoder_ready, tlast; cmd_done pulse.
// Build option: define INSTGEN_STALL_CNT_EN to add stall_cnt[31:0] (cycles with inst_valid && !decoder_ready,
//        cleared on command accept, saturating).
module instgen_tiled
  import instgen_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FRAM_AW    = 14,
  parameter int KRAM_AW    = 12,
  parameter int CHOUT_TILE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  feature_baseaddr,
  input  logic [ADDR_W-1:0]  kernel_baseaddr,
  input  logic [ADDR_W-1:0]  output_baseaddr,
  input  logic [DATA_W-1:0]  feature_width,
  input  logic [DATA_W-1:0]  feature_height,
  input  logic [DATA_W-1:0]  feature_chin,
  input  logic [DATA_W-1:0]  feature_chout,
  input  logic [DATA_W-1:0]  output_width,
  input  logic [DATA_W-1:0]  output_height,
  input  logic [7:0]         kernel_sizeh,
  input  logic [7:0]         kernel_sizew,
  input  logic [7:0]         stride_h,
  input  logic [7:0]         stride_w,
  input  logic               has_bias,
  input  logic               has_relu,
  input  logic               csrcmd_valid,
  output logic               instgen_ready,
  output logic [FRAM_AW-1:0] inst_feature_baseaddr,
  output logic [KRAM_AW-1:0] inst_kernel_baseaddr,
  output logic [FRAM_AW-1:0] inst_wb_baseaddr,
  output logic [DATA_W-1:0]  inst_wb_ch_offset,
  output logic [DATA_W-1:0]  inst_chout_cnt,
  output logic [DATA_W-1:0]  inst_feature_chin,
  output logic [DATA_W-1:0]  inst_feature_width,
  output logic [DATA_W-1:0]  inst_feature_height,
  output logic [7:0]         inst_kernel_sizeh,
  output logic [7:0]         inst_kernel_sizew,
  output logic               inst_has_bias,
  output logic               inst_has_relu,
  output logic               inst_valid,
  input  logic               decoder_ready,
  output logic               tlast,
  output logic               cmd_done
`ifdef INSTGEN_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  localparam logic [DATA_W-1:0] CT_D  = DATA_W'(CHOUT_TILE);
  localparam logic [DATA_W-1:0] ONE_D = DATA_W'(1);

  // ---------------------------------------------------------------- state
  state_t state_q, state_d;
  logic   init_ph_q;   // second INIT cycle

  // ---------------------------------------------------------------- captured command
  logic [FRAM_AW-1:0] fbase_q, obase_q;
  logic [KRAM_AW-1:0] kbase_q;
  logic [DATA_W-1:0]  fw_q, fh_q, chin_q, chout_q, ow_q, oh_q;
  logic [7:0]         sh_q, sw_q;
  inst_fixed_t        fix_q;

  // ---------------------------------------------------------------- precomputed steps
  logic [DATA_W-1:0]  row_step_q, plane_q, ck_q, ktile_q, wtile_q;

  // ---------------------------------------------------------------- loop position (of the next instruction to load)
  logic [DATA_W-1:0]  ox_q, oy_q, rem_q;   // rem_q = channels left from the current tile on

  logic [FRAM_AW-1:0] col_acc, row_acc, wbtile_acc, wb_acc;
  logic [KRAM_AW-1:0] k_acc;

  logic accept, init_done, zero_dim, fire, load_inst;
  logic last_col, last_row, last_tile, wrap_tile;

  assign accept    = csrcmd_valid && (state_q == IDLE);
  assign init_done = (state_q == INIT) && init_ph_q;
  assign zero_dim  = (ow_q == '0) || (oh_q == '0) || (chout_q == '0);
  assign fire      = inst_valid && decoder_ready;
  // Load the next instruction on the priming cycle of EXEC and after every non-final handshake.
  assign load_inst = (state_q == EXEC) && (!inst_valid || (decoder_ready && !tlast));

  assign last_col  = (ox_q == ow_q - ONE_D);
  assign last_row  = (oy_q == oh_q - ONE_D);
  assign last_tile = (rem_q <= CT_D);
  assign wrap_tile = last_col && last_row;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      init_ph_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_ph_q <= (state_q == INIT) && !init_ph_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    instgen_ready = 1'b0;
    cmd_done      = 1'b0;
    case (state_q)
      IDLE: begin
        instgen_ready = 1'b1;
        if (csrcmd_valid) state_d = INIT;
      end
      INIT: begin
        if (init_ph_q) state_d = zero_dim ? DONE : EXEC;
      end
      EXEC: begin
        if (fire && tlast) state_d = DONE;
      end
      DONE: begin
        cmd_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- command capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fbase_q <= '0; kbase_q <= '0; obase_q <= '0;
      fw_q <= '0; fh_q <= '0; chin_q <= '0; chout_q <= '0; ow_q <= '0; oh_q <= '0;
      sh_q <= '0; sw_q <= '0; fix_q <= '0;
    end else if (accept) begin
      fbase_q <= feature_baseaddr[BYTE2WORD_SH +: FRAM_AW];
      kbase_q <= kernel_baseaddr[BYTE2WORD_SH +: KRAM_AW];
      obase_q <= output_baseaddr[BYTE2WORD_SH +: FRAM_AW];
      fw_q    <= feature_width;
      fh_q    <= feature_height;
      chin_q  <= feature_chin;
      chout_q <= feature_chout;
      ow_q    <= output_width;
      oh_q    <= output_height;
      // A zero stride would make every pixel read the same window; treat it as 1.
      sh_q    <= (stride_h == 8'd0) ? 8'd1 : stride_h;
      sw_q    <= (stride_w == 8'd0) ? 8'd1 : stride_w;
      fix_q   <= '{kernel_sizeh: kernel_sizeh, kernel_sizew: kernel_sizew,
                   has_bias: has_bias, has_relu: has_relu};
    end
  end

  // ---------------------------------------------------------------- INIT: two-stage products
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_step_q <= '0; plane_q <= '0; ck_q <= '0; ktile_q <= '0; wtile_q <= '0;
    end else if (state_q == INIT) begin
      if (!init_ph_q) begin
        row_step_q <= DATA_W'(sh_q) * fw_q;
        plane_q    <= ow_q * oh_q;
        ck_q       <= chin_q * DATA_W'(fix_q.kernel_sizeh) * DATA_W'(fix_q.kernel_sizew);
      end else begin
        ktile_q    <= ck_q * CT_D;
        wtile_q    <= plane_q * CT_D;
      end
    end
  end

  // ---------------------------------------------------------------- loop counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ox_q <= '0; oy_q <= '0; rem_q <= '0;
    end else if (init_done) begin
      ox_q  <= '0;
      oy_q  <= '0;
      rem_q <= chout_q;
    end else if (load_inst) begin
      ox_q <= last_col ? '0 : ox_q + ONE_D;
      if (last_col) oy_q <= last_row ? '0 : oy_q + ONE_D;
      if (wrap_tile) rem_q <= rem_q - CT_D;
    end
  end

  // ---------------------------------------------------------------- address accumulators
  instgen_addr_acc #(.AW(FRAM_AW)) u_col_acc (
    .clk(clk), .rst(rst),
    .clr(init_done || (load_inst && last_col)),
    .load(1'b0), .load_val('0),
    .step(load_inst), .step_val(FRAM_AW'(sw_q)),
    .acc(col_acc)
  );

  instgen_addr_acc #(.AW(FRAM_AW)) u_row_acc (
    .clk(clk), .rst(rst),
    .clr(init_done || (load_inst && wrap_tile)),
    .load(1'b0), .load_val('0),
    .step(load_inst && last_col), .step_val(row_step_q[FRAM_AW-1:0]),
    .acc(row_acc)
  );

  instgen_addr_acc #(.AW(KRAM_AW)) u_k_acc (
    .clk(clk), .rst(rst),
    .clr(1'b0),
    .load(init_done), .load_val(kbase_q),
    .step(load_inst && wrap_tile), .step_val(ktile_q[KRAM_AW-1:0]),
    .acc(k_acc)
  );

  instgen_addr_acc #(.AW(FRAM_AW)) u_wbtile_acc (
    .clk(clk), .rst(rst),
    .clr(1'b0),
    .load(init_done), .load_val(obase_q),
    .step(load_inst && wrap_tile), .step_val(wtile_q[FRAM_AW-1:0]),
    .acc(wbtile_acc)
  );

  // Write-back walks +1 per pixel inside a tile and jumps to the next tile base on wrap.
  instgen_addr_acc #(.AW(FRAM_AW)) u_wb_acc (
    .clk(clk), .rst(rst),
    .clr(1'b0),
    .load(init_done || (load_inst && wrap_tile)),
    .load_val(init_done ? obase_q : wbtile_acc + wtile_q[FRAM_AW-1:0]),
    .step(load_inst), .step_val(FRAM_AW'(1)),
    .acc(wb_acc)
  );

  // ---------------------------------------------------------------- instruction register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_feature_baseaddr <= '0;
      inst_kernel_baseaddr  <= '0;
      inst_wb_baseaddr      <= '0;
      inst_wb_ch_offset     <= '0;
      inst_chout_cnt        <= '0;
      inst_feature_chin     <= '0;
      inst_feature_width    <= '0;
      inst_feature_height   <= '0;
      inst_kernel_sizeh     <= '0;
      inst_kernel_sizew     <= '0;
      inst_has_bias         <= 1'b0;
      inst_has_relu         <= 1'b0;
      inst_valid            <= 1'b0;
      tlast                 <= 1'b0;
    end else if (fire && tlast) begin
      inst_valid <= 1'b0;
      tlast      <= 1'b0;
    end else if (load_inst) begin
      inst_feature_baseaddr <= fbase_q + row_acc + col_acc;
      inst_kernel_baseaddr  <= k_acc;
      inst_wb_baseaddr      <= wb_acc;
      inst_wb_ch_offset     <= plane_q;
      inst_chout_cnt        <= last_tile ? rem_q : CT_D;
      inst_feature_chin     <= chin_q;
      inst_feature_width    <= fw_q;
      inst_feature_height   <= fh_q;
      inst_kernel_sizeh     <= fix_q.kernel_sizeh;
      inst_kernel_sizew     <= fix_q.kernel_sizew;
      inst_has_bias         <= fix_q.has_bias;
      inst_has_relu         <= fix_q.has_relu;
      inst_valid            <= 1'b1;
      tlast                 <= wrap_tile && last_tile;
    end
  end

`ifdef INSTGEN_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if (inst_valid && !decoder_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  // No stall accounting in this build.
`endif

  // Address bits outside the word window and the high product bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{feature_baseaddr, kernel_baseaddr, output_baseaddr,
                         row_step_q, ktile_q, wtile_q};

endmodule

// File: tb/tb_instgen_tiled.sv
// Randomised bench for instgen_tiled against a nested-loop reference model.
module tb_instgen_tiled;

  localparam int  CT    = 8;
  localparam longint FMASK = 64'h3FFF;
  localparam longint KMASK = 64'hFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] feature_baseaddr, kernel_baseaddr, output_baseaddr;
  logic [31:0] feature_width, feature_height, feature_chin, feature_chout;
  logic [31:0] output_width, output_height;
  logic [7:0]  kernel_sizeh, kernel_sizew, stride_h, stride_w;
  logic        has_bias, has_relu, csrcmd_valid, instgen_ready;
  logic [13:0] inst_feature_baseaddr, inst_wb_baseaddr;
  logic [11:0] inst_kernel_baseaddr;
  logic [31:0] inst_wb_ch_offset, inst_chout_cnt;
  logic [31:0] inst_feature_chin, inst_feature_width, inst_feature_height;
  logic [7:0]  inst_kernel_sizeh, inst_kernel_sizew;
  logic        inst_has_bias, inst_has_relu, inst_valid, decoder_ready, tlast, cmd_done;
`ifdef INSTGEN_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  instgen_tiled u_dut (
    .clk(clk), .rst(rst),
    .feature_baseaddr(feature_baseaddr), .kernel_baseaddr(kernel_baseaddr),
    .output_baseaddr(output_baseaddr),
    .feature_width(feature_width), .feature_height(feature_height),
    .feature_chin(feature_chin), .feature_chout(feature_chout),
    .output_width(output_width), .output_height(output_height),
    .kernel_sizeh(kernel_sizeh), .kernel_sizew(kernel_sizew),
    .stride_h(stride_h), .stride_w(stride_w),
    .has_bias(has_bias), .has_relu(has_relu),
    .csrcmd_valid(csrcmd_valid), .instgen_ready(instgen_ready),
    .inst_feature_baseaddr(inst_feature_baseaddr), .inst_kernel_baseaddr(inst_kernel_baseaddr),
    .inst_wb_baseaddr(inst_wb_baseaddr), .inst_wb_ch_offset(inst_wb_ch_offset),
    .inst_chout_cnt(inst_chout_cnt), .inst_feature_chin(inst_feature_chin),
    .inst_feature_width(inst_feature_width), .inst_feature_height(inst_feature_height),
    .inst_kernel_sizeh(inst_kernel_sizeh), .inst_kernel_sizew(inst_kernel_sizew),
    .inst_has_bias(inst_has_bias), .inst_has_relu(inst_has_relu),
    .inst_valid(inst_valid), .decoder_ready(decoder_ready),
    .tlast(tlast), .cmd_done(cmd_done)
`ifdef INSTGEN_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    longint fw, fh, chin, chout, ow, oh, kh, kw, sh, sw, fb, kb, ob;
    bit     bias, relu;
  } cmd_t;

  typedef struct {
    longint f, k, w, cnt;
    bit     last;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, want);
  endtask

  // Reference: walk tiles, rows, columns directly with multiplications.
  task automatic build_model(input cmd_t c);
    longint sh, sw, ntile, plane;
    exp_t   e;
    exp_q.delete();
    sh    = (c.sh == 0) ? 1 : c.sh;
    sw    = (c.sw == 0) ? 1 : c.sw;
    ntile = (c.chout + CT - 1) / CT;
    plane = c.ow * c.oh;
    for (longint t = 0; t < ntile; t++)
      for (longint oy = 0; oy < c.oh; oy++)
        for (longint ox = 0; ox < c.ow; ox++) begin
          e.f    = ((c.fb >> 2) + oy * sh * c.fw + ox * sw) & FMASK;
          e.k    = ((c.kb >> 2) + t * CT * c.chin * c.kh * c.kw) & KMASK;
          e.w    = ((c.ob >> 2) + t * CT * plane + oy * c.ow + ox) & FMASK;
          e.cnt  = (c.chout - t * CT < CT) ? c.chout - t * CT : CT;
          e.last = (t == ntile - 1) && (oy == c.oh - 1) && (ox == c.ow - 1);
          exp_q.push_back(e);
        end
  endtask

  function automatic cmd_t mk(longint fw, longint fh, longint chin, longint chout,
                              longint ow, longint oh, longint k, longint sh, longint sw);
    cmd_t c;
    c.fw = fw; c.fh = fh; c.chin = chin; c.chout = chout; c.ow = ow; c.oh = oh;
    c.kh = k; c.kw = k; c.sh = sh; c.sw = sw;
    c.fb = 64'h1000; c.kb = 64'h200; c.ob = 64'h8000; c.bias = 1'b1; c.relu = 1'b0;
    return c;
  endfunction

  task automatic run_cmd(input cmd_t c, input int rdy_pct, input int abort_after);
    int   cyc, consumed, last_fire, stalls, total;
    bit   hold, seen_valid, finished;
    logic [127:0] cur, saved;
    exp_t e;
    build_model(c);
    total = exp_q.size();
    feature_baseaddr = 32'(c.fb); kernel_baseaddr = 32'(c.kb); output_baseaddr = 32'(c.ob);
    feature_width = 32'(c.fw); feature_height = 32'(c.fh);
    feature_chin = 32'(c.chin); feature_chout = 32'(c.chout);
    output_width = 32'(c.ow); output_height = 32'(c.oh);
    kernel_sizeh = 8'(c.kh); kernel_sizew = 8'(c.kw);
    stride_h = 8'(c.sh); stride_w = 8'(c.sw);
    has_bias = c.bias; has_relu = c.relu;
    decoder_ready = 1'b0;
    csrcmd_valid  = 1'b1;
    chk("ready_idle", instgen_ready, 1);
    @(posedge clk); #1;
    csrcmd_valid = 1'b0;
    chk("ready_busy", instgen_ready, 0);
    cyc = 0; consumed = 0; last_fire = 0; stalls = 0;
    hold = 0; seen_valid = 0; finished = 0; saved = '0;
    while (!finished && cyc < 3000) begin
      if (abort_after >= 0 && consumed == abort_after) begin
        decoder_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_valid", inst_valid, 0);
        chk("rst_faddr", inst_feature_baseaddr, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_done", cmd_done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_idle_ready", instgen_ready, 1);
        chk("rst_idle_valid", inst_valid, 0);
        exp_q.delete();
        return;
      end
      if (cmd_done) begin
        chk("done_cycle", cyc, (total == 0) ? 2 : last_fire + 1);
        chk("inst_count", consumed, total);
        finished = 1;
      end else if (inst_valid) begin
        cur = {inst_feature_baseaddr, inst_kernel_baseaddr, inst_wb_baseaddr,
               inst_chout_cnt, inst_wb_ch_offset, tlast};
        if (!seen_valid) begin
          chk("first_latency", cyc, 3);
          seen_valid = 1;
        end
        if (hold) chk("stall_hold", cur, saved);
        decoder_ready = ($urandom_range(99) < rdy_pct);
        if (decoder_ready) begin
          if (exp_q.size() == 0) chk("extra_inst", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("feat_addr", inst_feature_baseaddr, e.f);
            chk("kern_addr", inst_kernel_baseaddr, e.k);
            chk("wb_addr", inst_wb_baseaddr, e.w);
            chk("chout_cnt", inst_chout_cnt, e.cnt);
            chk("tlast", tlast, e.last);
            chk("wb_ch_off", inst_wb_ch_offset, c.ow * c.oh);
            chk("copied", {inst_feature_chin, inst_feature_width, inst_feature_height,
                           inst_kernel_sizeh, inst_kernel_sizew, inst_has_bias, inst_has_relu},
                          {32'(c.chin), 32'(c.fw), 32'(c.fh), 8'(c.kh), 8'(c.kw), c.bias, c.relu});
          end
          consumed++;
          last_fire = cyc;
          hold = 0;
        end else begin
          stalls++;
          hold  = 1;
          saved = cur;
        end
      end else begin
        if (hold) chk("valid_dropped", 0, 1);
        hold = 0;
        decoder_ready = 1'($urandom_range(1));
      end
      if (!finished) begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (!finished) chk("timeout", 0, 1);
    else begin
      @(posedge clk); #1;
      chk("done_pulse_1cyc", cmd_done, 0);
      chk("ready_back", instgen_ready, 1);
`ifdef INSTGEN_STALL_CNT_EN
      chk("stall_cnt", stall_cnt, stalls);
`endif
    end
    decoder_ready = 1'b0;
  endtask

  initial begin
    cmd_t c;
    rst = 1'b1; csrcmd_valid = 1'b0; decoder_ready = 1'b0;
    feature_baseaddr = '0; kernel_baseaddr = '0; output_baseaddr = '0;
    feature_width = '0; feature_height = '0; feature_chin = '0; feature_chout = '0;
    output_width = '0; output_height = '0; kernel_sizeh = '0; kernel_sizew = '0;
    stride_h = '0; stride_w = '0; has_bias = 1'b0; has_relu = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", inst_valid, 0);
    chk("reset_tlast", tlast, 0);
    chk("reset_done", cmd_done, 0);
    chk("reset_ready", instgen_ready, 1);
    chk("reset_fields", {inst_feature_baseaddr, inst_kernel_baseaddr, inst_wb_baseaddr,
                         inst_chout_cnt, inst_wb_ch_offset}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_cmd(mk(6, 6, 4, 8, 4, 4, 3, 1, 1), 100, -1);   // basic 16-instruction run
    run_cmd(mk(8, 7, 2, 8, 2, 3, 3, 2, 3), 100, -1);   // asymmetric strides
    run_cmd(mk(6, 6, 3, 20, 2, 2, 3, 1, 1), 100, -1);  // three channel tiles
    run_cmd(mk(6, 6, 3, 20, 2, 2, 3, 1, 1), 30, -1);   // tiles under heavy backpressure
    run_cmd(mk(6, 6, 4, 8, 4, 4, 3, 1, 1), 30, -1);    // basic under backpressure
    run_cmd(mk(6, 6, 4, 8, 0, 4, 3, 1, 1), 100, -1);   // zero output width
    run_cmd(mk(6, 6, 4, 0, 4, 4, 3, 1, 1), 100, -1);   // zero output channels
    run_cmd(mk(6, 6, 4, 8, 4, 4, 3, 1, 1), 70, 5);     // reset after 5 instructions
    run_cmd(mk(6, 6, 4, 8, 4, 4, 3, 0, 0), 100, -1);   // clean run after reset, zero strides

    for (int i = 0; i < 8; i++) begin
      c.fw = $urandom_range(1, 10);  c.fh = $urandom_range(1, 10);
      c.chin = $urandom_range(1, 4); c.chout = $urandom_range(1, 20);
      c.ow = $urandom_range(1, 4);   c.oh = $urandom_range(1, 4);
      c.kh = $urandom_range(1, 3);   c.kw = $urandom_range(1, 3);
      c.sh = $urandom_range(0, 3);   c.sw = $urandom_range(0, 3);
      c.fb = longint'($urandom);     c.kb = longint'($urandom);
      c.ob = longint'($urandom);
      c.bias = 1'($urandom_range(1)); c.relu = 1'($urandom_range(1));
      run_cmd(c, $urandom_range(30, 100), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
